// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core sharing one memory port between instruction fetch and load/store.
// Sequencing is FETCH -> DECODE -> EXEC -> (MEM) -> (WB); an unknown opcode or funct parks the core in HALT.
module mips_multicycle_core #(
    parameter int unsigned ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              halt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0]  RA_IDX    = 5'd31;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [2:0]        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       npc_q, npc_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              retire_q, retire_d;
    logic              halt_q, halt_d;

    logic [31:0]       rf_q [32];
    logic              rf_we_c;
    logic [4:0]        rf_waddr_c;
    logic [31:0]       rf_wdata_c;

    logic [5:0]        opcode_c, funct_c;
    logic [4:0]        rs_c, rt_c, rd_c, shamt_c;
    logic [31:0]       simm_c, zimm_c, jtarget_c, btarget_c, ea_c, alu_c;
    logic              legal_c, is_alu_c, commit_c;
    logic [31:0]       next_pc_c;

    assign opcode_c  = ir_q[31:26];
    assign rs_c      = ir_q[25:21];
    assign rt_c      = ir_q[20:16];
    assign rd_c      = ir_q[15:11];
    assign shamt_c   = ir_q[10:6];
    assign funct_c   = ir_q[5:0];
    assign simm_c    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zimm_c    = {16'h0000, ir_q[15:0]};
    assign jtarget_c = {npc_q[31:28], ir_q[25:0], 2'b00};
    assign btarget_c = npc_q + (simm_c << 2);
    assign ea_c      = a_q + simm_c;

    // Instruction legality and ALU-class decode
    always_comb begin
        legal_c  = 1'b1;
        is_alu_c = 1'b0;
        case (opcode_c)
            OP_RTYPE: begin
                case (funct_c)
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_SLT, FN_SLL, FN_SRL: is_alu_c = 1'b1;
                    FN_JR:                  legal_c  = 1'b1;
                    default:                legal_c  = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI:               is_alu_c = 1'b1;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: legal_c = 1'b1;
            default:                                legal_c  = 1'b0;
        endcase
    end

    always_comb begin
        alu_c = '0;
        case (opcode_c)
            OP_RTYPE: begin
                case (funct_c)
                    FN_ADD:  alu_c = a_q + b_q;
                    FN_SUB:  alu_c = a_q - b_q;
                    FN_AND:  alu_c = a_q & b_q;
                    FN_OR:   alu_c = a_q | b_q;
                    FN_SLT:  alu_c = {31'd0, $signed(a_q) < $signed(b_q)};
                    FN_SLL:  alu_c = b_q << shamt_c;
                    FN_SRL:  alu_c = b_q >> shamt_c;
                    default: alu_c = '0;
                endcase
            end
            OP_ADDI: alu_c = a_q + simm_c;
            OP_ANDI: alu_c = a_q & zimm_c;
            OP_ORI:  alu_c = a_q | zimm_c;
            default: alu_c = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        npc_d       = npc_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        retire_d    = 1'b0;
        halt_d      = 1'b0;
        rf_we_c     = 1'b0;
        rf_waddr_c  = '0;
        rf_wdata_c  = '0;
        commit_c    = 1'b0;
        next_pc_c   = npc_q;

        case (state_q)
            S_FETCH: begin
                if (mem_req_q && mem_ack) begin
                    ir_d    = mem_rdata;
                    npc_d   = pc_q + 32'd4;
                    state_d = S_DECODE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = ADDR_W'(pc_q & WORD_MASK);
                end
            end
            S_DECODE: begin
                if (!legal_c) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    a_d     = (rs_c == 5'd0) ? 32'd0 : rf_q[rs_c];
                    b_d     = (rt_c == 5'd0) ? 32'd0 : rf_q[rt_c];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu_c) begin
                    alu_d   = alu_c;
                    state_d = S_WB;
                end else if (opcode_c == OP_LW || opcode_c == OP_SW) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (opcode_c == OP_SW);
                    mem_addr_d  = ADDR_W'(ea_c & WORD_MASK);
                    mem_wdata_d = b_q;
                    state_d     = S_MEM;
                end else begin
                    commit_c = 1'b1;
                    case (opcode_c)
                        OP_BEQ:  next_pc_c = (a_q == b_q) ? btarget_c : npc_q;
                        OP_BNE:  next_pc_c = (a_q != b_q) ? btarget_c : npc_q;
                        OP_J:    next_pc_c = jtarget_c;
                        OP_JAL: begin
                            next_pc_c  = jtarget_c;
                            rf_we_c    = 1'b1;
                            rf_waddr_c = RA_IDX;
                            rf_wdata_c = npc_q;
                        end
                        default: next_pc_c = a_q;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (opcode_c == OP_SW) begin
                        commit_c = 1'b1;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                rf_waddr_c = (opcode_c == OP_RTYPE) ? rd_c : rt_c;
                rf_wdata_c = (opcode_c == OP_LW) ? mdr_q : alu_q;
                commit_c   = 1'b1;
            end
            S_HALT: begin
                halt_d = 1'b1;
            end
            default: begin
                halt_d  = 1'b1;
                state_d = S_HALT;
            end
        endcase

        // Commit returns to FETCH with the next request already raised
        if (commit_c) begin
            pc_d       = next_pc_c;
            retire_d   = 1'b1;
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = ADDR_W'(next_pc_c & WORD_MASK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            npc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            npc_q       <= npc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            retire_q    <= retire_d;
            halt_q      <= halt_d;
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we_c && rf_waddr_c != 5'd0) begin
            rf_q[rf_waddr_c] <= rf_wdata_c;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halt      = halt_q;

endmodule
